mmind_player: RTL
=================

# mmind_player

Automated codebreaker for the `mmind` Mastermind block: it drives `mmind`'s `switches`, `setans_btn` and `guess_btn` inputs and reads back its seven-segment score outputs. It decodes each displayed score and steers a deterministic search until it has solved the 4-peg, 4-colour code. It sits beside `mmind` in self-test builds and in benches, replacing the human player.

## Interface
- `PULSE_CYC`, default 1: cycles `guess_btn` is held high per guess (legal range ≥1).
- `SETTLE_CYC`, default 4: cycles waited after `guess_btn` falls before the score is sampled (legal range ≥1).
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `start`  in  1: begin a solve; sampled only in IDLE, DONE or ERR.
- `secret`  in  8: code loaded via `setans_btn`; present only with `PLAYER_SETANS_EN`.
- `ca`..`cg`  in  1 each: `mmind` segment outputs, active-low.
- `switches`  out  8: current code; pegs are p3=[7:6], p2=[5:4], p1=[3:2], p0=[1:0].
- `guess_btn`  out  1: guess strobe to `mmind`.
- `setans_btn`  out  1: set-answer strobe to `mmind`.
- `busy`  out  1: solve in progress.
- `done`  out  1: solved; held until the next accepted `start`.
- `error`  out  1: solve aborted; held until the next accepted `start`.
- `solved_code`  out  8: the solved code; valid while `done`=1.
- `guess_count`  out  4: number of guesses issued in the current or last solve.

## Operation
- **Reset values.** All outputs are 0; the state is IDLE.
- **Score decode.** The score is the exact-position match count. `{ca..cg}` maps as follows: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4. Any other pattern is invalid.
- **States and transitions.**
  - IDLE → SETANS if `PLAYER_SETANS_EN` is defined, otherwise IDLE → DRIVE.
  - DRIVE → PULSE → SETTLE → SAMPLE → EVAL.
  - EVAL → DRIVE, DONE or ERR.
  - DONE and ERR → IDLE on `start`. The `start` edge that leaves DONE/ERR also acts as a new start.
- **Search.**
  - Guess 1 is 8'h00. Its score is stored as `n0`, 3 bits.
  - Positions are then resolved in the order p3, p2, p1, p0.
  - For each position p, the guess is colour c at p and 0 at every other peg, tried with c=1, then c=2.
    - score = `n0`+1: p=c.
    - score = `n0`−1: p=0.
    - score = `n0`: advance c.
    - If both c=1 and c=2 return `n0`, then p=3 without a further guess.
  - After all four positions are resolved, a final guess of the assembled code is issued.
- **Termination.**
  - Any sampled score of 4 → DONE, with `solved_code` set to that guess.
  - → ERR on any of: an invalid pattern; a score outside {`n0`−1, `n0`, `n0`+1} during the per-position guesses; the final guess scoring ≠4; `guess_count` exceeding 10.
- **Maximum.** A solve issues at most 10 guesses.
- **start while busy.** Ignored.
- **Reset mid-solve.** Outputs return to their reset values at the next edge, including a `guess_btn` pulse already in progress.

## Timing
- **DRIVE.** 1 cycle. `switches` is updated; both buttons are 0.
- **PULSE.** `guess_btn` is 1 for exactly `PULSE_CYC` cycles. `switches` is stable throughout, and stays stable until SAMPLE.
- **SETTLE.** `SETTLE_CYC` cycles with `guess_btn`=0.
- **SAMPLE.** Segments are registered in 1 cycle.
- **EVAL.** 1 cycle.
- **guess_count.** Increments on the first cycle of PULSE.
- **Per-guess latency.** `PULSE_CYC`+`SETTLE_CYC`+3 cycles, which is 8 cycles at the defaults.
- **SETANS.** `switches`=`secret` for 1 cycle. Then `setans_btn`=1 for 2 cycles. Then 1 idle cycle before DRIVE.
- **busy.** 1 from the cycle after an accepted `start`. It drops in the same cycle that `done` or `error` rises.

## Configuration
- **`PLAYER_SETANS_EN` defined.** The `secret` port exists, and the SETANS phase loads the answer into `mmind` before guessing.
- **`PLAYER_SETANS_EN` undefined.** There is no `secret` port. `setans_btn` is tied to 0, and the solve starts at DRIVE. In this build the answer is loaded externally.

## Structure
- **`mmind_pkg`.** Holds:
  - the state enum;
  - the five segment-pattern constants;
  - `PEG_W`=2 and `NUM_PEGS`=4;
  - `MAX_GUESSES`=10.
- **`mmind_seg_decode`.** One combinational sub-module: 7-bit segments in, `{valid, score[2:0]}` out. It is shared with any future display checker.

## Test plan
- **Secret 8'hC3**, paired with a real `mmind`. Guess sequence: 00, 40, 80, 10, 04, 01, 02, C3 → `done`=1, `solved_code`=C3, `guess_count`=8.
- **Secret 8'hFF.** Final guess FF → `done`=1, `guess_count`=10, no error.
- **Secret 8'h00.** First guess scores 4 → `done`=1, `guess_count`=1.
- **Model forces segments to 7'b1111111 at SAMPLE** → `error`=1, `busy`=0, `done`=0. The next `start` restarts with `guess_count`=1.
- **`reset` driven low on the 2nd PULSE cycle** (with `PULSE_CYC`=3) → next edge shows `guess_btn`=0, `switches`=0 and all flags 0.
- **`start` pulsed while `busy`** → no restart; `guess_count` continues from its current value.

Source files
------------

// File: rtl/mmind_pkg.sv
// mmind_pkg: shared definitions for the automated Mastermind codebreaker.
//   - player FSM state enum and guess-kind enum
//   - active-low seven-segment patterns ({ca..cg}) for scores 0..4
//   - code geometry (PEG_W, NUM_PEGS) and the guess budget (MAX_GUESSES)
//   - helpers that build a guess word from a peg position and colour
package mmind_pkg;

  localparam int PEG_W       = 2;
  localparam int NUM_PEGS    = 4;
  localparam int CODE_W      = PEG_W * NUM_PEGS;
  localparam int MAX_GUESSES = 10;

  // {ca,cb,cc,cd,ce,cf,cg}, segments lit when 0
  localparam logic [6:0] SEG_SCORE0 = 7'b0000001;
  localparam logic [6:0] SEG_SCORE1 = 7'b1001111;
  localparam logic [6:0] SEG_SCORE2 = 7'b0010010;
  localparam logic [6:0] SEG_SCORE3 = 7'b0000110;
  localparam logic [6:0] SEG_SCORE4 = 7'b1001100;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SA_LOAD,
    ST_SA_PRESS,
    ST_SA_GAP,
    ST_DRIVE,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE,
    ST_ERR
  } player_state_e;

  // Which phase of the search the next guess belongs to
  typedef enum logic [1:0] {
    GK_FIRST,
    GK_PROBE,
    GK_FINAL
  } guess_kind_e;

  // Return code with peg 'pos' replaced by 'colour'
  function automatic logic [CODE_W-1:0] place_peg(
    input logic [CODE_W-1:0] code,
    input logic [1:0]        pos,
    input logic [PEG_W-1:0]  colour
  );
    logic [CODE_W-1:0] r;
    r = code;
    r[int'(pos)*PEG_W +: PEG_W] = colour;
    return r;
  endfunction

  // Guess word for a given search phase: all-zero opener, a single
  // coloured peg on a zero background, or the fully assembled code
  function automatic logic [CODE_W-1:0] guess_word(
    input guess_kind_e       kind,
    input logic [1:0]        pos,
    input logic [PEG_W-1:0]  colour,
    input logic [CODE_W-1:0] code
  );
    logic [CODE_W-1:0] g;
    g = '0;
    unique case (kind)
      GK_FIRST: g = '0;
      GK_PROBE: g = place_peg('0, pos, colour);
      GK_FINAL: g = code;
      default:  g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mmind_seg_decode.sv
// mmind_seg_decode: turns an mmind active-low seven-segment score digit
// back into a number.
//   seg_i [6:0] : {ca,cb,cc,cd,ce,cf,cg} as driven by mmind
//   dec_o [3:0] : {valid, score[2:0]}; valid=0 for any pattern that is not
//                 one of the five score digits (score is then 0)
// Purely combinational so it can also sit in a display checker.
module mmind_seg_decode
  import mmind_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] dec_o
);

  always_comb begin
    dec_o = 4'b0000;
    unique case (seg_i)
      SEG_SCORE0: dec_o = {1'b1, 3'd0};
      SEG_SCORE1: dec_o = {1'b1, 3'd1};
      SEG_SCORE2: dec_o = {1'b1, 3'd2};
      SEG_SCORE3: dec_o = {1'b1, 3'd3};
      SEG_SCORE4: dec_o = {1'b1, 3'd4};
      default:    dec_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mmind_player.sv
// mmind_player: automated codebreaker for the mmind Mastermind block.
// Drives mmind's switches / guess_btn / setans_btn, reads the score back
// from its seven-segment outputs and runs a fixed search:
//   guess 00 to learn n0 (number of zero pegs), then for p3..p0 probe
//   colour 1 and 2 on a zero background, then issue the assembled code.
//
// Parameters
//   PULSE_CYC  : cycles guess_btn is held high per guess (>=1)
//   SETTLE_CYC : cycles after guess_btn falls before the score is sampled (>=1)
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous, active-low
//   start        : begin a solve (honoured only in IDLE, DONE, ERR)
//   secret[7:0]  : answer loaded through setans_btn (PLAYER_SETANS_EN only)
//   ca..cg       : mmind segment outputs, active-low
//   switches[7:0]: current code driven to mmind, p3=[7:6] .. p0=[1:0]
//   guess_btn    : guess strobe
//   setans_btn   : set-answer strobe (tied 0 without PLAYER_SETANS_EN)
//   busy         : solve in progress
//   done         : solved; held until the next accepted start
//   error        : solve aborted; held until the next accepted start
//   solved_code  : solved code, valid while done
//   guess_count  : guesses issued in the current or last solve
//
// Configuration macro: PLAYER_SETANS_EN adds the secret port and a SETANS
// phase that loads the answer into mmind before guessing.
module mmind_player
  import mmind_pkg::*;
#(
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef PLAYER_SETANS_EN
  input  logic [7:0] secret,
`endif
  input  logic       ca,
  input  logic       cb,
  input  logic       cc,
  input  logic       cd,
  input  logic       ce,
  input  logic       cf,
  input  logic       cg,
  output logic [7:0] switches,
  output logic       guess_btn,
  output logic       setans_btn,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] solved_code,
  output logic [3:0] guess_count
);

  localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYC - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SETANS_LAST = 16'd1;

  player_state_e     state_q, state_d;
  guess_kind_e       kind_q, kind_d;
  logic [1:0]        pos_q, pos_d;
  logic [PEG_W-1:0]  colour_q, colour_d;
  logic [2:0]        n0_q, n0_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] switches_q, switches_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        guess_count_q, guess_count_d;
  logic [CODE_W-1:0] solved_q, solved_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [6:0]        seg_now;
  logic [3:0]        dec;
  logic              dec_valid;
  logic [2:0]        dec_score;
  logic [3:0]        score_ext;
  logic [3:0]        n0_ext;
  logic              resolve;
  logic [PEG_W-1:0]  peg_val;

  assign seg_now = {ca, cb, cc, cd, ce, cf, cg};

  // The decoder looks at the registered segments, so EVAL sees a
  // value that was stable for a whole cycle.
  mmind_seg_decode u_seg_decode (
    .seg_i (seg_q),
    .dec_o (dec)
  );

  assign dec_valid = dec[3];
  assign dec_score = dec[2:0];
  assign score_ext = {1'b0, dec_score};
  assign n0_ext    = {1'b0, n0_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      kind_q        <= GK_FIRST;
      pos_q         <= 2'd3;
      colour_q      <= 2'd1;
      n0_q          <= '0;
      code_q        <= '0;
      switches_q    <= '0;
      seg_q         <= '0;
      guess_count_q <= '0;
      solved_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      pos_q         <= pos_d;
      colour_q      <= colour_d;
      n0_q          <= n0_d;
      code_q        <= code_d;
      switches_q    <= switches_d;
      seg_q         <= seg_d;
      guess_count_q <= guess_count_d;
      solved_q      <= solved_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pos_d         = pos_q;
    colour_d      = colour_q;
    n0_d          = n0_q;
    code_d        = code_q;
    switches_d    = switches_q;
    seg_d         = seg_q;
    guess_count_d = guess_count_q;
    solved_d      = solved_q;
    cnt_d         = cnt_q;
    resolve       = 1'b0;
    peg_val       = '0;

    unique case (state_q)
      // DONE and ERR accept start exactly like IDLE, so one start both
      // leaves the terminal state and begins the next solve.
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          kind_d        = GK_FIRST;
          pos_d         = 2'd3;
          colour_d      = 2'd1;
          n0_d          = '0;
          code_d        = '0;
          guess_count_d = '0;
          cnt_d         = '0;
`ifdef PLAYER_SETANS_EN
          state_d       = ST_SA_LOAD;
`else
          state_d       = ST_DRIVE;
`endif
        end
      end

      ST_SA_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SA_PRESS;
      end

      ST_SA_PRESS: begin
        if (cnt_q == SETANS_LAST) begin
          cnt_d   = '0;
          state_d = ST_SA_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SA_GAP: begin
        state_d = ST_DRIVE;
      end

      ST_DRIVE: begin
        cnt_d         = '0;
        guess_count_d = guess_count_q + 4'd1;
        state_d       = ST_PULSE;
      end

      ST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SAMPLE: begin
        seg_d   = seg_now;
        state_d = ST_EVAL;
      end

      // A score of 4 ends the solve whatever phase the guess was in.
      // During probing only n0-1, n0, n0+1 are possible from a real
      // mmind; anything else means the display or the answer is corrupt.
      ST_EVAL: begin
        state_d = ST_DRIVE;
        if (!dec_valid) begin
          state_d = ST_ERR;
        end else if (dec_score == 3'd4) begin
          solved_d = switches_q;
          state_d  = ST_DONE;
        end else if (guess_count_q > 4'(MAX_GUESSES)) begin
          state_d = ST_ERR;
        end else begin
          unique case (kind_q)
            GK_FIRST: begin
              n0_d     = dec_score;
              kind_d   = GK_PROBE;
              pos_d    = 2'd3;
              colour_d = 2'd1;
            end
            GK_PROBE: begin
              if (score_ext == n0_ext + 4'd1) begin
                resolve = 1'b1;
                peg_val = colour_q;
              end else if (score_ext + 4'd1 == n0_ext) begin
                resolve = 1'b1;
                peg_val = 2'd0;
              end else if (score_ext == n0_ext) begin
                // Neither 0, 1 nor 2: after colour 2 the peg must be 3
                if (colour_q == 2'd1) begin
                  colour_d = 2'd2;
                end else begin
                  resolve = 1'b1;
                  peg_val = 2'd3;
                end
              end else begin
                state_d = ST_ERR;
              end
            end
            default: state_d = ST_ERR;
          endcase
        end

        if (resolve) begin
          code_d   = place_peg(code_q, pos_q, peg_val);
          colour_d = 2'd1;
          if (pos_q == 2'd0) begin
            kind_d = GK_FINAL;
          end else begin
            pos_d = pos_q - 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // switches changes only on entry to DRIVE (and SA_LOAD), so it is
    // already stable for the whole of PULSE, SETTLE and SAMPLE.
    if (state_d == ST_DRIVE) begin
      switches_d = guess_word(kind_d, pos_d, colour_d, code_d);
    end
`ifdef PLAYER_SETANS_EN
    if (state_d == ST_SA_LOAD) begin
      switches_d = secret;
    end
`endif
  end

  assign switches    = switches_q;
  assign guess_btn   = (state_q == ST_PULSE);
`ifdef PLAYER_SETANS_EN
  assign setans_btn  = (state_q == ST_SA_PRESS);
`else
  assign setans_btn  = 1'b0;
`endif
  assign busy        = !((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                         (state_q == ST_ERR));
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERR);
  assign solved_code = solved_q;
  assign guess_count = guess_count_q;

endmodule
